// File: rtl/mult_rr_scheduler.sv
// mult_rr_scheduler: shares one pipelined signed fixed-point multiplier
// among N_REQ requesters. A round-robin arbiter grants one operand pair per
// cycle. A 3-stage multiply / round / saturate pipeline returns each result
// tagged with its requester index. Saturated results are counted.
//
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset
//   i_enable        grant enable; pipeline drains while low
//   i_req_valid     per-requester operand valid
//   i_a, i_b        packed operands, requester k at [k*W +: W]
//   o_req_ready     one-hot grant (combinational)
//   o_res_valid     result strobe, 3 cycles after transfer
//   o_res_data      rounded/saturated product S(NBS,NBFS)
//   o_res_id        originating requester index
//   o_res_sat       result was saturated
//   i_sat_clr       synchronous clear of o_sat_count
//   o_sat_count     saturating count of saturated results
module mult_rr_scheduler #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned NBA   = 12,
    parameter int unsigned NBFA  = 11,
    parameter int unsigned NBB   = 8,
    parameter int unsigned NBFB  = 6,
    parameter int unsigned NBS   = 10,
    parameter int unsigned NBFS  = 9,
    parameter int unsigned NBC   = 16
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_enable,
    input  logic [N_REQ-1:0]                i_req_valid,
    input  logic [N_REQ*NBA-1:0]            i_a,
    input  logic [N_REQ*NBB-1:0]            i_b,
    output logic [N_REQ-1:0]                o_req_ready,
    output logic                            o_res_valid,
    output logic [NBS-1:0]                  o_res_data,
    output logic [$clog2(N_REQ)-1:0]        o_res_id,
    output logic                            o_res_sat,
    input  logic                            i_sat_clr,
    output logic [NBC-1:0]                  o_sat_count
);

    localparam int unsigned IDW = $clog2(N_REQ);
    localparam int unsigned NBP = NBA + NBB;
    localparam int unsigned D   = NBFA + NBFB - NBFS;

    // Representable result range, expressed one bit wider than the product.
    localparam logic signed [NBP:0] R_MAX = (NBP+1)'((64'd1 << (NBS-1)) - 64'd1);
    localparam logic signed [NBP:0] R_MIN = ~R_MAX;

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------
    logic [IDW-1:0]   r_last;
    logic [N_REQ-1:0] w_grant;
    logic [IDW-1:0]   w_gid;
    logic [IDW-1:0]   w_idx;
    logic             w_found;

    // Search last+1 .. last (mod N_REQ); first valid requester wins.
    always_comb begin
        w_grant = '0;
        w_gid   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            w_idx = IDW'((32'(r_last) + i) % N_REQ);
            if (!w_found && i_enable && i_req_valid[w_idx]) begin
                w_found        = 1'b1;
                w_grant[w_idx] = 1'b1;
                w_gid          = w_idx;
            end
        end
    end

    assign o_req_ready = w_grant;

    // A grant is only ever issued to a valid requester, so found == transfer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= IDW'(N_REQ - 1);
        end else if (w_found) begin
            r_last <= w_gid;
        end
    end

    logic [NBA-1:0] w_a;
    logic [NBB-1:0] w_b;
    assign w_a = i_a[w_gid*NBA +: NBA];
    assign w_b = i_b[w_gid*NBB +: NBB];

    // ------------------------------------------------------------------
    // Stage 1: capture granted operands
    // ------------------------------------------------------------------
    logic                  r_v1;
    logic signed [NBA-1:0] r_a1;
    logic signed [NBB-1:0] r_b1;
    logic [IDW-1:0]        r_id1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v1  <= 1'b0;
            r_a1  <= '0;
            r_b1  <= '0;
            r_id1 <= '0;
        end else begin
            r_v1 <= w_found;
            if (w_found) begin
                r_a1  <= w_a;
                r_b1  <= w_b;
                r_id1 <= w_gid;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: full-precision signed product
    // ------------------------------------------------------------------
    logic                  r_v2;
    logic signed [NBP-1:0] r_p2;
    logic [IDW-1:0]        r_id2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v2  <= 1'b0;
            r_p2  <= '0;
            r_id2 <= '0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_p2  <= NBP'(r_a1) * NBP'(r_b1);
                r_id2 <= r_id1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: round half-up, then saturate
    // ------------------------------------------------------------------
    logic signed [NBP:0] w_pext;
    logic signed [NBP:0] w_r;
    logic                w_sat_hi;
    logic                w_sat_lo;
    logic                w_sat;
    logic [NBS-1:0]      w_data;

    // One guard bit so adding the half-LSB to the largest product cannot wrap.
    assign w_pext = {r_p2[NBP-1], r_p2};

    generate
        if (D > 0) begin : g_round
            localparam logic signed [NBP:0] W_HALF = (NBP+1)'(1) << (D - 1);
            assign w_r = (w_pext + W_HALF) >>> D;
        end else begin : g_noround
            assign w_r = w_pext;
        end
    endgenerate

    assign w_sat_hi = (w_r > R_MAX);
    assign w_sat_lo = (w_r < R_MIN);
    assign w_sat    = w_sat_hi | w_sat_lo;

    always_comb begin
        w_data = w_r[NBS-1:0];
        if (w_sat_hi) begin
            w_data = {1'b0, {(NBS-1){1'b1}}};
        end else if (w_sat_lo) begin
            w_data = {1'b1, {(NBS-1){1'b0}}};
        end
    end

    // Result port holds its last value between strobes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_res_valid <= 1'b0;
            o_res_data  <= '0;
            o_res_id    <= '0;
            o_res_sat   <= 1'b0;
        end else begin
            o_res_valid <= r_v2;
            if (r_v2) begin
                o_res_data <= w_data;
                o_res_id   <= r_id2;
                o_res_sat  <= w_sat;
            end
        end
    end

    // Counts on the same edge that registers a saturated result; clear wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sat_count <= '0;
        end else if (i_sat_clr) begin
            o_sat_count <= '0;
        end else if (r_v2 && w_sat && (o_sat_count != '1)) begin
            o_sat_count <= o_sat_count + NBC'(1);
        end
    end

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Self-checking bench for mult_rr_scheduler (default parameters).
// Scoreboard queue is filled when a transfer is observed and drained when
// o_res_valid is seen; an independent arbiter model checks o_req_ready.
module tb_mult_rr_scheduler;

    localparam int N   = 4;
    localparam int NBA = 12;
    localparam int NBB = 8;
    localparam int NBS = 10;
    localparam int D   = 11 + 6 - 9;

    typedef struct {
        logic [NBS-1:0] data;
        logic [1:0]     id;
        logic           sat;
        int             cyc;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               enable;
    logic [N-1:0]       valid;
    logic [N*NBA-1:0]   a_bus;
    logic [N*NBB-1:0]   b_bus;
    logic [N-1:0]       ready;
    logic               res_valid;
    logic [NBS-1:0]     res_data;
    logic [1:0]         res_id;
    logic               res_sat;
    logic               sat_clr;
    logic [15:0]        sat_count;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_m  = N - 1;
    exp_t sbq[$];
    int   gq[$];

    always #5 clk = ~clk;

    mult_rr_scheduler dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_enable    (enable),
        .i_req_valid (valid),
        .i_a         (a_bus),
        .i_b         (b_bus),
        .o_req_ready (ready),
        .o_res_valid (res_valid),
        .o_res_data  (res_data),
        .o_res_id    (res_id),
        .o_res_sat   (res_sat),
        .i_sat_clr   (sat_clr),
        .o_sat_count (sat_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference arithmetic: exact product, round half-up, clamp.
    function automatic exp_t model(input int k, input logic [NBA-1:0] a, input logic [NBB-1:0] b);
        exp_t e;
        int   pa, pb, p, r;
        pa = $signed(a);
        pb = $signed(b);
        p  = pa * pb;
        r  = (D > 0) ? ((p + (1 << (D - 1))) >>> D) : p;
        if (r > 511) begin
            e.data = 10'h1FF; e.sat = 1'b1;
        end else if (r < -512) begin
            e.data = 10'h200; e.sat = 1'b1;
        end else begin
            e.data = 10'(r); e.sat = 1'b0;
        end
        e.id  = 2'(k);
        e.cyc = cyc;
        return e;
    endfunction

    // One clock: check grant and result at negedge, then advance past posedge.
    task automatic tick();
        logic [N-1:0] expg;
        int           g;
        exp_t         e;
        @(negedge clk);
        if (res_valid) begin
            if (sbq.size() == 0) begin
                chk("res_unexpected", 32'(res_valid), 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("res_data", 32'(res_data), 32'(e.data));
                chk("res_id", 32'(res_id), 32'(e.id));
                chk("res_sat", 32'(res_sat), 32'(e.sat));
                chk("res_latency", 32'(cyc - e.cyc), 32'd3);
            end
        end else if (sbq.size() > 0 && sbq[0].cyc + 3 <= cyc) begin
            chk("res_missing", 32'(res_valid), 32'd1);
            void'(sbq.pop_front());
        end
        expg = '0;
        g    = -1;
        if (enable) begin
            for (int i = 1; i <= N; i++) begin
                int k;
                k = (last_m + i) % N;
                if (g < 0 && valid[k]) g = k;
            end
        end
        if (g >= 0) expg[g] = 1'b1;
        chk("grant", 32'(ready), 32'(expg));
        if (g >= 0) begin
            last_m = g;
            gq.push_back(g);
            sbq.push_back(model(g, a_bus[g*NBA +: NBA], b_bus[g*NBB +: NBB]));
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input int k, input logic [NBA-1:0] a, input logic [NBB-1:0] b);
        valid[k] = 1'b1;
        a_bus[k*NBA +: NBA] = a;
        b_bus[k*NBB +: NBB] = b;
        tick();
        valid[k] = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid = '0;
        #1;
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_sat_count", 32'(sat_count), 32'd0);
        sbq.delete();
        gq.delete();
        last_m = N - 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int ord1[8];
        int ord2[4];
        ord1 = '{0, 1, 2, 3, 0, 1, 2, 3};
        ord2 = '{0, 2, 3, 0};

        rst_n   = 1'b0;
        enable  = 1'b1;
        valid   = '0;
        a_bus   = '0;
        b_bus   = '0;
        sat_clr = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_res_sat", 32'(res_sat), 32'd0);
        chk("rst_sat_count", 32'(sat_count), 32'd0);
        rst_n = 1'b1;

        // Single request on requester 2: 0.5 * 1.0
        issue(2, 12'h400, 8'h40);
        drain(4);
        chk("single_data_reg", 32'(res_data), 32'h100);
        chk("single_id_reg", 32'(res_id), 32'd2);

        // Rounding, back-to-back on requester 0
        issue(0, 12'h001, 8'h7F);
        issue(0, 12'h002, 8'h40);
        issue(0, 12'hFFF, 8'h7F);
        drain(4);
        chk("round_neg_data", 32'(res_data), 32'h000);
        chk("sat_count_round", 32'(sat_count), 32'd0);

        // Saturation corners
        issue(1, 12'h7FF, 8'h7F);
        issue(1, 12'h800, 8'hC0);
        issue(1, 12'h800, 8'h40);
        drain(4);
        chk("neg_one_data", 32'(res_data), 32'h200);
        chk("sat_count_two", 32'(sat_count), 32'd2);

        // Clear coincides with a third saturation being registered
        issue(3, 12'h7FF, 8'h7F);
        tick();
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        tick();
        chk("sat_clr_wins", 32'(sat_count), 32'd0);
        drain(2);

        // Fairness from reset with all requesters valid
        do_reset();
        for (int k = 0; k < N; k++) begin
            a_bus[k*NBA +: NBA] = 12'(12'h100 * (k + 1) + k);
            b_bus[k*NBB +: NBB] = 8'(8'h20 + 8'(k * 3));
        end
        valid = 4'hF;
        drain(8);
        for (int i = 0; i < 8; i++) chk("rr_order_all", 32'(gq[i]), 32'(ord1[i]));
        gq.delete();
        valid[1] = 1'b0;
        drain(4);
        for (int i = 0; i < 4; i++) chk("rr_order_skip1", 32'(gq[i]), 32'(ord2[i]));

        // Enable low: no grants, pipeline drains, resume from last+1
        valid  = 4'hF;
        enable = 1'b0;
        drain(2);
        chk("enable_low_ready", 32'(ready), 32'd0);
        tick();
        chk("drain_done_valid", 32'(res_valid), 32'd0);
        enable = 1'b1;
        gq.delete();
        tick();
        chk("resume_grant", 32'(gq[0]), 32'd1);

        // Reset with results in flight
        drain(3);
        do_reset();
        drain(5);
        chk("post_rst_idle", 32'(res_valid), 32'd0);
        valid = 4'hF;
        gq.delete();
        tick();
        chk("post_rst_first", 32'(gq[0]), 32'd0);
        valid = '0;
        drain(4);
        chk("queue_empty", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_rr_scheduler.md
# mult_rr_scheduler

Shares one pipelined signed fixed-point multiplier among N_REQ requesters. A round-robin arbiter grants one operand pair per cycle. A 3-stage multiply / round / saturate pipeline returns each result tagged with the requester index. Sits between the filter/equalizer taps and the shared multiplier resource, and tracks saturation events for the datapath monitor.

## Interface
- N_REQ, 4, number of requesters (2..8)
- NBA, 12, width of operand A, format S(NBA,NBFA)
- NBFA, 11, fractional bits of A
- NBB, 8, width of operand B, format S(NBB,NBFB)
- NBFB, 6, fractional bits of B
- NBS, 10, result width, format S(NBS,NBFS)
- NBFS, 9, fractional bits of result; constraint NBFS <= NBFA+NBFB
- NBC, 16, width of saturation counter

- i_clk  in  1  single clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_enable  in  1  when low, no new grants; pipeline keeps draining
- i_req_valid  in  N_REQ  per-requester operand valid
- i_a  in  N_REQ*NBA  operand A, requester k at [k*NBA +: NBA]
- i_b  in  N_REQ*NBB  operand B, requester k at [k*NBB +: NBB]
- o_req_ready  out  N_REQ  one-hot (or zero) grant, combinational
- o_res_valid  out  1  result valid, one-cycle pulse per accepted request
- o_res_data  out  NBS  rounded, saturated product S(NBS,NBFS)
- o_res_id  out  clog2(N_REQ)  index of originating requester
- o_res_sat  out  1  result was saturated
- i_sat_clr  in  1  synchronous clear of saturation counter
- o_sat_count  out  NBC  saturating count of saturated results

## Operation
- Arbiter holds pointer `last` (index of last grant).
  - Reset value: N_REQ-1, so requester 0 has first priority.
  - Each cycle with i_enable=1, o_req_ready asserts for the first k in order last+1, last+2, ..., last (mod N_REQ) with i_req_valid[k]=1.
  - At most one bit of o_req_ready is set. It is zero when i_enable=0 or no valid is set.
- Transfer occurs when i_req_valid[k] & o_req_ready[k]. On a transfer, `last` <= k. With no transfer, `last` holds.
- A requester keeps valid and operands stable until its transfer. A requester dropping valid before its grant is legal; it simply gets no grant.
- Stage 1: register i_a[k], i_b[k], id k and a valid bit.
- Stage 2: full signed product P, NBA+NBB bits, format S(NBA+NBB, NBFA+NBFB). Register P, id and valid.
- Stage 3: rounding and saturation, registered into the outputs.
  - Let D = NBFA+NBFB-NBFS (bits dropped).
  - Round half-up: R = (P + 2^(D-1)) >>> D, computed one bit wider than P, so P=max cannot wrap. When D=0, R=P.
  - If R > 2^(NBS-1)-1, output 0x1FF-style max ({0,1...1}) and set sat=1.
  - If R < -2^(NBS-1), output {1,0...0} and set sat=1.
  - Otherwise output R[NBS-1:0] and set sat=0.
- o_res_data, o_res_id and o_res_sat are meaningful only when o_res_valid=1. They hold their last value otherwise.
- Saturation counter:
  - Increments when o_res_valid & o_res_sat are registered, and stops at 2^NBC-1.
  - i_sat_clr forces 0. Clear wins over a simultaneous increment.

## Timing
- Reset values (async, while i_rst_n=0): all pipeline valids 0, o_res_valid=0, o_res_data=0, o_res_id=0, o_res_sat=0, o_sat_count=0, last=N_REQ-1.
- Latency: a transfer in cycle t gives o_res_valid=1 in cycle t+3.
- Throughput is one result per cycle; there is no backpressure on the result port.
- Results leave in grant order.
- i_enable falling: the grant is removed the same cycle. Up to 3 in-flight results still emerge on cycles t+1..t+3.
- Reset asserted mid-operation: all in-flight results are discarded; none emerge after reset release.
- o_req_ready is combinational from i_req_valid, i_enable and `last`. There is no combinational path from any input to o_res_*.

## Test plan
- Single request, A=0x400 (0.5), B=0x40 (1.0) on requester 2 at cycle t -> o_res_valid at t+3, o_res_data=0x100, o_res_id=2, o_res_sat=0.
- Rounding: A=0x001, B=0x7F (P=127) -> data 0x000. A=0x002, B=0x40 (P=128, exact half) -> data 0x001. A=0xFFF, B=0x7F (P=-127) -> data 0x000.
- Saturation: A=0x7FF, B=0x7F -> data 0x1FF, sat=1. A=0x800, B=0xC0 (+1.0) -> 0x1FF, sat=1. A=0x800, B=0x40 (-1.0) -> 0x200, sat=0. After these, o_sat_count=2; assert i_sat_clr in the same cycle as a third saturation -> count 0.
- Fairness: all 4 valids held high for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3 and o_res_id follows the same sequence 3 cycles later. Drop valid[1] -> order 0,2,3,0.
- i_enable low for 2 cycles with all valids high -> o_req_ready=0 in those cycles; the pipeline drains 3 results; grants resume from last+1.
- Reset asserted with 3 results in flight -> o_res_valid=0 immediately and stays 0 after release until new transfers; first grant after release goes to requester 0.
